// File: rtl/sync_arith_pkg.sv
// rtl/sync_arith_pkg.sv - shared types and constants for the arithmetic scheduler and ALU
package sync_arith_pkg;

  // Scheduler phases: waiting for a request, waiting on the ALU, presenting a response
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  localparam int STATUS_W = 4;
  localparam int OP_W     = 2;

  // Op codes understood by the shared ALU; the scheduler forwards them untouched
  localparam logic [OP_W-1:0] OP_ADD = 2'd0;
  localparam logic [OP_W-1:0] OP_SUB = 2'd1;
  localparam logic [OP_W-1:0] OP_AND = 2'd2;
  localparam logic [OP_W-1:0] OP_XOR = 2'd3;

  // Status bit positions: negative, zero, carry/borrow, signed overflow
  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

endpackage

// File: rtl/arith_rr_pick.sv
// rtl/arith_rr_pick.sv - combinational round-robin picker over a request vector
module arith_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan starting just past the previous winner, wrapping N_REQ-1 -> 0; first hit wins
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last_grant_i) + k) % N_REQ);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        grant_o[cand]  = 1'b1;
        idx_o          = cand;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/sync_arith_unit_12.sv
// rtl/sync_arith_unit_12.sv - shared pipelined ALU with registered result and status
module sync_arith_unit_12
  import sync_arith_pkg::*;
#(
  parameter int BITS    = 32,
  parameter int LATENCY = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [BITS-1:0]     i_arg_A,
  input  logic [BITS-1:0]     i_arg_B,
  input  logic [OP_W-1:0]     i_op,
  output logic [BITS-1:0]     o_result,
  output logic [STATUS_W-1:0] o_status
);

  logic [BITS:0]         wide;
  logic [BITS-1:0]       res_d;
  logic                  carry;
  logic                  ovf;
  logic [STATUS_W-1:0]   stat_d;
  logic [BITS-1:0]       res_q  [LATENCY];
  logic [STATUS_W-1:0]   stat_q [LATENCY];

  // Compute result and flags; carry on subtract is the borrow out of A-B
  always_comb begin
    wide  = '0;
    res_d = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (i_op)
      OP_ADD: begin
        wide  = {1'b0, i_arg_A} + {1'b0, i_arg_B};
        res_d = wide[BITS-1:0];
        carry = wide[BITS];
        ovf   = (i_arg_A[BITS-1] == i_arg_B[BITS-1]) && (res_d[BITS-1] != i_arg_A[BITS-1]);
      end
      OP_SUB: begin
        wide  = {1'b0, i_arg_A} - {1'b0, i_arg_B};
        res_d = wide[BITS-1:0];
        carry = wide[BITS];
        ovf   = (i_arg_A[BITS-1] != i_arg_B[BITS-1]) && (res_d[BITS-1] != i_arg_A[BITS-1]);
      end
      OP_AND: res_d = i_arg_A & i_arg_B;
      default: res_d = i_arg_A ^ i_arg_B;
    endcase
    stat_d           = '0;
    stat_d[ST_N]     = res_d[BITS-1];
    stat_d[ST_Z]     = (res_d == '0);
    stat_d[ST_C]     = carry;
    stat_d[ST_V]     = ovf;
  end

  // Delay line so the result appears LATENCY edges after the operands
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        res_q[i]  <= '0;
        stat_q[i] <= '0;
      end
    end else begin
      res_q[0]  <= res_d;
      stat_q[0] <= stat_d;
      for (int i = 1; i < LATENCY; i++) begin
        res_q[i]  <= res_q[i-1];
        stat_q[i] <= stat_q[i-1];
      end
    end
  end

  assign o_result = res_q[LATENCY-1];
  assign o_status = stat_q[LATENCY-1];

endmodule

// File: rtl/arith_unit_scheduler.sv
// rtl/arith_unit_scheduler.sv - round-robin scheduler sharing one external ALU among requesters
module arith_unit_scheduler
  import sync_arith_pkg::*;
#(
  parameter int BITS        = 32,
  parameter int N_REQ       = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [N_REQ-1:0]            i_req_valid,
  output logic [N_REQ-1:0]            o_req_ready,
  input  logic [N_REQ-1:0][BITS-1:0]  i_req_arg_A,
  input  logic [N_REQ-1:0][BITS-1:0]  i_req_arg_B,
  input  logic [N_REQ-1:0][OP_W-1:0]  i_req_op,
  output logic [BITS-1:0]             o_alu_arg_A,
  output logic [BITS-1:0]             o_alu_arg_B,
  output logic [OP_W-1:0]             o_alu_op,
  input  logic [BITS-1:0]             i_alu_result,
  input  logic [STATUS_W-1:0]         i_alu_status,
  output logic [N_REQ-1:0]            o_rsp_valid,
  input  logic [N_REQ-1:0]            i_rsp_ready,
  output logic [BITS-1:0]             o_rsp_result,
  output logic [STATUS_W-1:0]         o_rsp_status,
  output logic                        o_busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(ALU_LATENCY + 1);

  sched_state_t          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      grant_idx_q;
  logic [IDX_W-1:0]      last_grant_q;
  logic [BITS-1:0]       arg_a_q, arg_b_q;
  logic [OP_W-1:0]       op_q;
  logic [BITS-1:0]       rsp_result_q;
  logic [STATUS_W-1:0]   rsp_status_q;

  logic [N_REQ-1:0]      pick_grant;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_valid;
  logic                  accept;
  logic                  capture;
  logic                  rsp_ack;

  arith_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i        (i_req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_grant),
    .idx_o        (pick_idx),
    .valid_o      (pick_valid)
  );

  // A grant is only ever offered to a valid requester, so offering it in IDLE is acceptance
  assign accept  = (state_q == IDLE) && pick_valid;
  assign capture = (state_q == EXEC) && (cnt_q == '0);
  assign rsp_ack = i_rsp_ready[grant_idx_q];

  // FSM state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: accept -> wait out ALU latency -> hold response until its owner takes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)  state_d = EXEC;
      EXEC:    if (capture) state_d = RESP;
      RESP:    if (rsp_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: grant offered only in IDLE, response bus zeroed unless presenting
  always_comb begin
    o_req_ready  = '0;
    o_rsp_valid  = '0;
    o_rsp_result = '0;
    o_rsp_status = '0;
    o_busy       = (state_q != IDLE);
    if (state_q == IDLE && !i_reset) begin
      o_req_ready = pick_grant;
    end
    if (state_q == RESP) begin
      o_rsp_valid[grant_idx_q] = 1'b1;
      o_rsp_result             = rsp_result_q;
      o_rsp_status             = rsp_status_q;
    end
  end

  // Latency countdown: loaded on acceptance, runs down to zero while executing
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = CNT_W'(ALU_LATENCY);
    end else if (state_q == EXEC && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Latency counter register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Hold registers: snapshot the winner's operands so later requester changes cannot leak in
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      grant_idx_q  <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      arg_a_q      <= '0;
      arg_b_q      <= '0;
      op_q         <= '0;
    end else if (accept) begin
      grant_idx_q  <= pick_idx;
      last_grant_q <= pick_idx;
      arg_a_q      <= i_req_arg_A[pick_idx];
      arg_b_q      <= i_req_arg_B[pick_idx];
      op_q         <= i_req_op[pick_idx];
    end
  end

  // Response registers: take the ALU output once its latency has elapsed
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rsp_result_q <= '0;
      rsp_status_q <= '0;
    end else if (capture) begin
      rsp_result_q <= i_alu_result;
      rsp_status_q <= i_alu_status;
    end
  end

  assign o_alu_arg_A = arg_a_q;
  assign o_alu_arg_B = arg_b_q;
  assign o_alu_op    = op_q;

endmodule

// File: doc/arith_unit_scheduler.md
ARITH_UNIT_SCHEDULER -- requirements
Module: arith_unit_scheduler

Interface
REQ-001 Parameter BITS, 32, operand/result width.
REQ-002 Parameter N_REQ, 4, number of requesters (2..8).
REQ-003 Parameter ALU_LATENCY, 1, edges from ALU operand presentation to valid i_alu_result/i_alu_status (1..7).
REQ-004 i_clk  in  1  single clock, all state on rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_req_valid  in  N_REQ  per-requester request valid.
REQ-007 o_req_ready  out  N_REQ  per-requester accept, at most one bit high.
REQ-008 i_req_arg_A, i_req_arg_B  in  N_REQ x BITS  per-requester operands.
REQ-009 i_req_op  in  N_REQ x 2  per-requester op code, passed to ALU undecoded.
REQ-010 o_alu_arg_A, o_alu_arg_B  out  BITS  operands to shared ALU.
REQ-011 o_alu_op  out  2  op code to shared ALU.
REQ-012 i_alu_result  in  BITS; i_alu_status  in  4  registered ALU outputs.
REQ-013 o_rsp_valid  out  N_REQ  one-hot response valid, bit = owning requester.
REQ-014 i_rsp_ready  in  N_REQ  per-requester response accept.
REQ-015 o_rsp_result  out  BITS; o_rsp_status  out  4  shared response data bus.
REQ-016 o_busy  out  1  high in any state except IDLE.

Function
REQ-017 FSM states IDLE, EXEC, RESP; exactly one active.
REQ-018 IDLE: o_req_ready = one-hot round-robin grant over i_req_valid, combinational; all zero if no valid.
REQ-019 Round-robin: search starts at last_grant+1, wraps N_REQ-1 -> 0; last_grant updates only on request acceptance.
REQ-020 Acceptance edge (valid & ready): latch grant index, arg_A, arg_B, op into hold registers; load cnt = ALU_LATENCY; go EXEC.
REQ-021 o_alu_arg_A/B, o_alu_op driven from hold registers at all times; hold registers change only on acceptance.
REQ-022 EXEC: o_req_ready all zero; cnt decrements each edge while >0; edge with cnt==0 captures i_alu_result/i_alu_status into response registers, go RESP.
REQ-023 Response timing: o_rsp_valid asserts ALU_LATENCY+1 cycles after the acceptance edge.
REQ-024 RESP: o_rsp_valid[grant]=1, o_rsp_result/status stable; o_req_ready all zero; stays until i_rsp_ready[grant]=1, then IDLE on that edge.
REQ-025 i_rsp_ready bits for non-owning requesters ignored.
REQ-026 Requester rule: valid and operands held until ready; arbiter never samples operands outside acceptance edge; valid dropping before acceptance is legal, no side effect.
REQ-027 Operand/op changes after acceptance have no effect on in-flight result.
REQ-028 Back-to-back: request valid in IDLE after RESP exit is accepted in that first IDLE cycle; minimum issue interval ALU_LATENCY+3 cycles.
REQ-029 o_rsp_result/status zero when o_rsp_valid all zero.

Reset
REQ-030 i_reset asserts: state IDLE, cnt 0, hold/response registers 0, last_grant N_REQ-1 (requester 0 wins first), o_req_ready 0, o_rsp_valid 0, o_busy 0, o_alu_* 0, immediately without clock.
REQ-031 Reset mid-EXEC or mid-RESP drops the operation; no response delivered after release.
REQ-032 First acceptance possible in first cycle after reset deassertion.

Structure
REQ-033 Shared package sync_arith_pkg: sched_state_t enum (IDLE, EXEC, RESP), STATUS_W=4, OP_W=2.
REQ-034 One sub-module arith_rr_pick: combinational round-robin picker (request vector, last_grant -> one-hot grant, index).
REQ-035 Shared ALU is sync_arith_unit_12 on same i_clk/i_reset; scheduler contains no arithmetic.

Verification
REQ-036 Bench instantiates scheduler plus sync_arith_unit_12 (BITS=32, ALU_LATENCY=1), per-requester expected-result model.
REQ-037 Single request: req2 valid, A=5, B=3, op=0 -> ready=4'b0100 same cycle; o_alu_arg_A=5 next cycle; o_rsp_valid=4'b0100 2 cycles after accept, result/status equal ALU model.
REQ-038 All four valid continuously, rsp_ready tied high -> grants in order 0,1,2,3,0, each accepted every 4 cycles.
REQ-039 Backpressure: req1 response, i_rsp_ready[1]=0 for 10 cycles -> o_rsp_valid=4'b0010, result stable, o_req_ready 0 throughout; completes one edge after ready rises.
REQ-040 Operand change: after accept of A=0xFFFFFFFF, B=1, requester changes A to 0 -> response uses 0xFFFFFFFF.
REQ-041 Reset asserted during EXEC -> all outputs 0 asynchronously; no o_rsp_valid after release; next simultaneous req0/req3 grants req0.
